// File: rtl/fetch_stage_ctrl.sv
// fetch_stage_ctrl: PC owner, imem request/valid handshake and IF/ID register with freeze buffering.
// Optional FETCH_PERF_CNT_EN adds saturating freeze/bubble/flush counters.
module fetch_stage_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        freeze,
    input  logic        branchTaken,
    input  logic [31:0] branchAddr,
    output logic [31:0] imemAddr,
    output logic        imemReq,
    input  logic [31:0] imemRdata,
    input  logic        imemValid,
    output logic [31:0] instruction_ID,
    output logic [31:0] pc_ID,
    output logic        valid_ID,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] freezeCycles,
    output logic [31:0] bubbleCycles,
    output logic [31:0] flushCount,
`endif
    output logic        fetchStall
);
    typedef enum logic {FETCH, HOLD} state_t;
    state_t state, state_nx;
    logic [31:0] pc, pc_nx, hold_buf, hold_nx, instr_nx, pc_id_nx;
    logic valid_nx;
    assign imemAddr   = pc;
    assign imemReq    = rst_n && state == FETCH;
    assign fetchStall = rst_n && state == FETCH && !freeze && !branchTaken && !imemValid;
    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        hold_nx  = hold_buf;
        instr_nx = instruction_ID;
        pc_id_nx = pc_ID;
        valid_nx = valid_ID;
        if (branchTaken) begin
            state_nx = FETCH;
            pc_nx    = branchAddr;
            hold_nx  = NOP_WORD;
            instr_nx = NOP_WORD;
            valid_nx = 1'b0;
        end else if (state == HOLD) begin
            if (!freeze) begin
                state_nx = FETCH;
                pc_nx    = pc + PC_STEP;
                instr_nx = hold_buf;
                pc_id_nx = pc + PC_STEP;
                valid_nx = 1'b1;
            end
        end else if (!freeze) begin
            pc_nx    = imemValid ? pc + PC_STEP : pc;
            instr_nx = imemValid ? imemRdata : NOP_WORD;
            pc_id_nx = imemValid ? pc + PC_STEP : pc_ID;
            valid_nx = imemValid;
        end else if (imemValid) begin
            // frozen pipeline: park the word so it is neither lost nor refetched
            hold_nx  = imemRdata;
            state_nx = HOLD;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= FETCH;
            pc             <= RESET_PC;
            hold_buf       <= NOP_WORD;
            instruction_ID <= NOP_WORD;
            pc_ID          <= 32'd0;
            valid_ID       <= 1'b0;
        end else begin
            state          <= state_nx;
            pc             <= pc_nx;
            hold_buf       <= hold_nx;
            instruction_ID <= instr_nx;
            pc_ID          <= pc_id_nx;
            valid_ID       <= valid_nx;
        end
    end
`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            freezeCycles <= 32'd0;
            bubbleCycles <= 32'd0;
            flushCount   <= 32'd0;
        end else begin
            freezeCycles <= freezeCycles + {31'd0, freeze && !branchTaken && freezeCycles != '1};
            bubbleCycles <= bubbleCycles + {31'd0, fetchStall && bubbleCycles != '1};
            flushCount   <= flushCount + {31'd0, branchTaken && flushCount != '1};
        end
    end
`endif
endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// tb_fetch_stage_ctrl: scoreboard bench; ROM word at address a is 32'h1000_0000 + a.
// Counter checks compile only when FETCH_PERF_CNT_EN is defined.
module tb_fetch_stage_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        freeze = 1'b0, branchTaken = 1'b0, imemValid = 1'b0;
    logic [31:0] branchAddr = 32'd0;
    logic [31:0] imemAddr, imemRdata, instruction_ID, pc_ID;
    logic        imemReq, valid_ID, fetchStall;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] freezeCycles, bubbleCycles, flushCount;
`endif
    typedef struct {
        logic [31:0] i;
        logic [31:0] p;
    } exp_t;
    exp_t q[$];
    int total = 0, bad = 0;

    always #5 clk = ~clk;
    assign imemRdata = 32'h1000_0000 + imemAddr;

    fetch_stage_ctrl dut (
        .clk(clk), .rst_n(rst_n), .freeze(freeze), .branchTaken(branchTaken),
        .branchAddr(branchAddr), .imemAddr(imemAddr), .imemReq(imemReq),
        .imemRdata(imemRdata), .imemValid(imemValid), .instruction_ID(instruction_ID),
        .pc_ID(pc_ID), .valid_ID(valid_ID),
`ifdef FETCH_PERF_CNT_EN
        .freezeCycles(freezeCycles), .bubbleCycles(bubbleCycles), .flushCount(flushCount),
`endif
        .fetchStall(fetchStall)
    );

    function automatic logic [31:0] rom(input logic [31:0] a);
        return 32'h1000_0000 + a;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic f, input logic b, input logic [31:0] ba, input logic v);
        freeze = f;
        branchTaken = b;
        branchAddr = ba;
        imemValid = v;
        #1;
    endtask

    task automatic expect_word(input logic [31:0] i, input logic [31:0] p);
        q.push_back('{i: i, p: p});
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("sb_instr", instruction_ID, e.i);
            check("sb_pc", pc_ID, e.p);
            check("sb_valid", {31'd0, valid_ID}, 32'd1);
        end
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_instr"}, instruction_ID, 32'd0);
        check({tag, "_pc"}, pc_ID, 32'd0);
        check({tag, "_valid"}, {31'd0, valid_ID}, 32'd0);
        check({tag, "_stall"}, {31'd0, fetchStall}, 32'd0);
        check({tag, "_req"}, {31'd0, imemReq}, 32'd0);
        check({tag, "_addr"}, imemAddr, 32'd0);
    endtask

    initial begin
        // reset state
        drive(0, 0, 0, 1);
        @(posedge clk);
        #1;
        check_reset_vals("rst");
        rst_n = 1'b1;
        #1;
        check("first_req", {31'd0, imemReq}, 32'd1);
        // zero-wait streaming
        expect_word(rom(0), 4);
        tick();
        expect_word(rom(4), 8);
        tick();
        // two wait cycles at address 8
        drive(0, 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            check("wait_stall_comb", {31'd0, fetchStall}, 32'd1);
            tick();
            check("wait_addr", imemAddr, 32'd8);
            check("wait_valid", {31'd0, valid_ID}, 32'd0);
            check("wait_pcid", pc_ID, 32'd8);
        end
        drive(0, 0, 0, 1);
        check("wait_stall_off", {31'd0, fetchStall}, 32'd0);
        expect_word(rom(8), 12);
        tick();
        expect_word(rom(12), 16);
        tick();
        // freeze for 3 cycles while memory returns W1 at 4
        do_reset();
        expect_word(rom(0), 4);
        tick();
        drive(1, 0, 0, 1);
        check("frz_stall", {31'd0, fetchStall}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("frz_req", {31'd0, imemReq}, 32'd0);
            check("frz_instr", instruction_ID, rom(0));
            check("frz_pc", pc_ID, 32'd4);
            check("frz_addr", imemAddr, 32'd4);
        end
        drive(0, 0, 0, 1);
        expect_word(rom(4), 8);
        tick();
        check("unfrz_addr", imemAddr, 32'd8);
        expect_word(rom(8), 12);
        tick();
        // async reset in the middle of HOLD
        drive(1, 0, 0, 1);
        tick();
        check("hold_req", {31'd0, imemReq}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("arst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(0, 0, 0, 1);
        check("arst_req", {31'd0, imemReq}, 32'd1);
        check("arst_addr", imemAddr, 32'd0);
        expect_word(rom(0), 4);
        tick();
        // branch together with freeze and valid
        drive(1, 1, 32'h40, 1);
        check("br_stall", {31'd0, fetchStall}, 32'd0);
        tick();
        check("br_valid", {31'd0, valid_ID}, 32'd0);
        check("br_instr", instruction_ID, 32'd0);
        check("br_addr", imemAddr, 32'h40);
        check("br_pc", pc_ID, 32'd4);
        drive(0, 0, 0, 1);
        expect_word(rom(32'h40), 32'h44);
        tick();
        // branch out of HOLD, then PC wrap
        drive(1, 0, 0, 1);
        tick();
        drive(1, 1, 32'hFFFF_FFFC, 1);
        tick();
        check("brh_req", {31'd0, imemReq}, 32'd1);
        check("brh_addr", imemAddr, 32'hFFFF_FFFC);
        check("brh_valid", {31'd0, valid_ID}, 32'd0);
        drive(0, 0, 0, 1);
        expect_word(rom(32'hFFFF_FFFC), 32'd0);
        tick();
        check("wrap_addr", imemAddr, 32'd0);
        expect_word(rom(0), 4);
        tick();
`ifdef FETCH_PERF_CNT_EN
        do_reset();
        check("cnt_rst", freezeCycles | bubbleCycles | flushCount, 32'd0);
        drive(1, 0, 0, 0);
        repeat (3) tick();
        drive(0, 0, 0, 0);
        repeat (2) tick();
        drive(0, 1, 32'hFFFF_FFFC, 0);
        tick();
        drive(0, 0, 0, 1);
        expect_word(rom(32'hFFFF_FFFC), 32'd0);
        tick();
        check("cnt_freeze", freezeCycles, 32'd3);
        check("cnt_bubble", bubbleCycles, 32'd2);
        check("cnt_flush", flushCount, 32'd1);
        check("cnt_wrap", imemAddr, 32'd0);
`endif
        check("sb_empty", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fetch_stage_ctrl.md
Name: fetch_stage_ctrl

Overview:
- Instruction-fetch controller and IF/ID pipeline register.
- Acts on the stall and flush requests produced downstream: `freeze` from hazard detection and `branchTaken` from EXE.
- Owns the PC and runs a request/valid handshake with instruction memory.
- Buffers a returned instruction while the pipeline is frozen, so no fetch is lost or repeated.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_WORD, 32'h0000_0000, instruction word driven into IF/ID for a bubble or flush
PC_STEP, 4, PC increment per fetched instruction

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous, active-low reset
freeze  input  1  hold request from hazard detection; IF/ID and PC must not advance
branchTaken  input  1  taken branch resolved in EXE; redirect and flush
branchAddr  input  32  branch target, valid when branchTaken=1
imemAddr  output  32  instruction memory address (equals PC register)
imemReq  output  1  fetch request
imemRdata  input  32  instruction data, valid when imemValid=1
imemValid  input  1  memory response for the current imemAddr, same cycle
instruction_ID  output  32  IF/ID instruction
pc_ID  output  32  IF/ID PC+PC_STEP of that instruction
valid_ID  output  1  IF/ID holds a real instruction
fetchStall  output  1  high in any cycle where memory did not deliver and IF/ID loads a bubble

Behaviour:
- **Reset (async, rst_n=0):**
  - PC=RESET_PC; state=FETCH; holdBuf=NOP_WORD.
  - instruction_ID=NOP_WORD, pc_ID=0, valid_ID=0, fetchStall=0, imemReq=0.
  - First request is issued in the first cycle after rst_n deasserts.
- **Memory handshake:**
  - imemAddr=PC at all times.
  - imemReq=1 in FETCH and 0 in HOLD.
  - A transfer completes in a cycle with imemReq=1 and imemValid=1; imemRdata belongs to that cycle's imemAddr.
  - Memory may respond in the same cycle or after any number of wait cycles.
  - A changed imemAddr abandons any pending response.
- **FSM states:** FETCH, HOLD. Priority per cycle is branchTaken > freeze > memory.
- **branchTaken=1, any state:**
  - PC<=branchAddr; state<=FETCH.
  - IF/ID<={NOP_WORD, pc_ID unchanged, valid 0}; holdBuf discarded.
  - A simultaneous imemValid is ignored; freeze is ignored that cycle.
- **FETCH, freeze=0:**
  - If imemValid=1: IF/ID<={imemRdata, PC+PC_STEP, 1}; PC<=PC+PC_STEP.
  - If imemValid=0: IF/ID<={NOP_WORD, pc_ID, 0}; PC holds; fetchStall=1 (combinational).
- **FETCH, freeze=1:**
  - IF/ID holds.
  - If imemValid=1: holdBuf<=imemRdata; state<=HOLD; PC holds.
  - If imemValid=0: stay in FETCH with the request still asserted.
- **HOLD, freeze=1:** everything holds; imemReq=0.
- **HOLD, freeze=0:** IF/ID<={holdBuf, PC+PC_STEP, 1}; PC<=PC+PC_STEP; state<=FETCH.
- **fetchStall:** 0 whenever freeze=1 or branchTaken=1.
- **Arithmetic:** PC arithmetic is modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
- **Reset mid-wait or mid-HOLD:** returns to the reset values above; the buffered word is lost.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- **When defined:**
  - Adds three 32-bit outputs: freezeCycles, bubbleCycles, flushCount.
  - freezeCycles counts cycles with freeze=1 and branchTaken=0.
  - bubbleCycles counts cycles with fetchStall=1.
  - flushCount counts cycles with branchTaken=1.
  - All three reset to 0 asynchronously and saturate at 32'hFFFF_FFFF.
- **When undefined:** the ports and counters are absent; the core behaviour is identical.

Test Plan:
- Zero-wait memory (imemValid tied 1), no freeze/branch, ROM words W0..W3 at 0,4,8,12:
  - Required: IF/ID shows W0/pc 4, W1/pc 8, W2/pc 12 on consecutive cycles after reset; valid_ID=1.
- imemValid low for 2 cycles at addr 8:
  - Required: two cycles with fetchStall=1 and valid_ID=0, then W2 with pc_ID=12.
  - Required: imemAddr stays 8 throughout.
- freeze=1 for 3 cycles while memory returns W1 at addr 4:
  - Required: state HOLD, imemReq=0, IF/ID keeps W0.
  - Required: after freeze drops, IF/ID=W1/pc 8 next cycle and imemAddr=8; W1 is not fetched twice.
- branchTaken=1, branchAddr=0x40, asserted together with freeze=1 and imemValid=1:
  - Required: next cycle valid_ID=0, instruction_ID=NOP_WORD, imemAddr=0x40.
  - Required: the next delivered instruction has pc_ID=0x44.
- rst_n pulsed low asynchronously mid-HOLD:
  - Required: all outputs at reset values immediately.
  - Required: after release, the fetch restarts at RESET_PC.
- With FETCH_PERF_CNT_EN defined, run 3 freeze cycles, 2 bubble cycles and 1 flush:
  - Required: freezeCycles=3, bubbleCycles=2, flushCount=1.
  - Required: PC starting at 0xFFFF_FFFC wraps to 0.
